// File: rtl/pipeline_stage_reg.sv
// Two-entry elastic pipeline stage: a main register drives the outputs and a skid
// register absorbs one beat, so in_ready can be registered without losing throughput.
//
// state | meaning
// EMPTY | no beat held, out_data shows NOP_VALUE
// ONE   | one beat in main register
// TWO   | main and skid both hold beats, upstream stalled
module pipeline_stage_reg #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_VALUE = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  nop_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, deliver;

  assign accept  = in_valid && in_ready_q;
  assign deliver = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = NOP_VALUE;
      skid_d  = NOP_VALUE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          case ({accept, deliver})
            2'b10: begin
              state_d = TWO;
              skid_d  = in_data;
            end
            2'b01: begin
              state_d = EMPTY;
              main_d  = NOP_VALUE;
            end
            2'b11: main_d = in_data;
            default: ;
          endcase
        end
        TWO: begin
          if (deliver) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VALUE;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VALUE;
          skid_d  = NOP_VALUE;
        end
      endcase
    end
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
    // Bubble counter samples the out_valid seen during the cycle just ending
    cnt_d = cnt_q;
    if (!out_valid_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= EMPTY;
      main_q      <= NOP_VALUE;
      skid_q      <= NOP_VALUE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign nop_count = cnt_q;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Bench for pipeline_stage_reg: directed scenarios plus a FIFO scoreboard that
// tracks accepted beats and checks every delivery.
module tb_pipeline_stage_reg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              nRST = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  nop_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit sb_on    = 1'b0;
  int n_deliv  = 0;
  logic [DATA_W-1:0] sb_q[$];
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  pipeline_stage_reg #(.DATA_W(DATA_W), .NOP_VALUE('0), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .nop_count(nop_count)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: sampled mid-cycle, before the edge that completes the handshake
  always @(negedge CLK) begin
    if (sb_on && nRST) begin
      n_checks++;
      if (occupancy > 2'd2) begin
        n_fail++;
        $display("FAIL sb_occupancy got=%0d limit=2", occupancy);
      end
      if (!out_valid) begin
        n_checks++;
        if (out_data !== '0) begin
          n_fail++;
          $display("FAIL sb_nop_data got=%h exp=%h", out_data, 32'h0);
        end
      end
      if (prev_stall && out_valid) begin
        n_checks++;
        if (out_data !== prev_data) begin
          n_fail++;
          $display("FAIL sb_stall_stable got=%h exp=%h", out_data, prev_data);
        end
      end
      if (out_valid && out_ready) begin
        n_checks++;
        n_deliv++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_beat got=%h exp=none", out_data);
        end else begin
          logic [DATA_W-1:0] exp_d;
          exp_d = sb_q.pop_front();
          if (out_data !== exp_d) begin
            n_fail++;
            $display("FAIL sb_order got=%h exp=%h", out_data, exp_d);
          end
        end
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_data);
      prev_stall = out_valid && !out_ready && !flush;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #2 nRST = 1'b0;
    #1;
    n_checks += 5;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
    if (nop_count !== '0) begin n_fail++; $display("FAIL rst_nop_count got=%0d exp=0", nop_count); end
    @(negedge CLK);
    nRST = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_in_ready got=%b exp=0", in_ready); end
    tick();
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_first_edge_in_ready got=%b exp=1", in_ready); end
    if (nop_count !== 4'd1) begin n_fail++; $display("FAIL rst_first_edge_nop got=%0d exp=1", nop_count); end
  endtask

  task automatic test_counter();
    repeat (13) tick();
    n_checks++;
    if (nop_count !== 4'd14) begin n_fail++; $display("FAIL cnt_14 got=%0d exp=14", nop_count); end
    tick();
    n_checks++;
    if (nop_count !== 4'd15) begin n_fail++; $display("FAIL cnt_15 got=%0d exp=15", nop_count); end
    repeat (5) tick();
    n_checks++;
    if (nop_count !== 4'd15) begin n_fail++; $display("FAIL cnt_saturate got=%0d exp=15", nop_count); end
  endtask

  task automatic test_stream();
    logic [DATA_W-1:0] exp_s[3];
    exp_s = '{32'h1, 32'h2, 32'h3};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = exp_s[i];
      tick();
      n_checks += 3;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); end
      if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, out_valid); end
      if (out_data !== exp_s[i]) begin n_fail++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, out_data, exp_s[i]); end
    end
    in_valid = 1'b0;
    tick();
    n_checks += 2;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL stream_drain_data got=%h exp=0", out_data); end
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    n_checks += 3;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL stall_occ got=%0d exp=2", occupancy); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
    if (out_data !== 32'hA) begin n_fail++; $display("FAIL stall_data got=%h exp=a", out_data); end
    in_data = 32'hDD;
    tick();
    n_checks += 2;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL stall_hold_occ got=%0d exp=2", occupancy); end
    if (out_data !== 32'hA) begin n_fail++; $display("FAIL stall_hold_data got=%h exp=a", out_data); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks += 3;
    if (out_data !== 32'hB) begin n_fail++; $display("FAIL stall_skid_data got=%h exp=b", out_data); end
    if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stall_skid_occ got=%0d exp=1", occupancy); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_skid_in_ready got=%b exp=1", in_ready); end
    tick();
    n_checks += 2;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL stall_empty_occ got=%0d exp=0", occupancy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_empty_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    n_checks++;
    if (occupancy !== 2'd2) begin n_fail++; $display("FAIL flush_pre_occ got=%0d exp=2", occupancy); end
    flush   = 1'b1;
    in_data = 32'hC;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks += 4;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_occ got=%0d exp=0", occupancy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL flush_data got=%h exp=0", out_data); end
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_resurrect got=%b exp=0", out_valid); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h55;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks += 2;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL flush_empty_occ got=%0d exp=0", occupancy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h77;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (occupancy !== 2'd1) begin n_fail++; $display("FAIL arst_pre_occ got=%0d exp=1", occupancy); end
    #2 nRST = 1'b0;
    #1;
    n_checks += 5;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL arst_occ got=%0d exp=0", occupancy); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid got=%b exp=0", out_valid); end
    if (out_data !== '0) begin n_fail++; $display("FAIL arst_data got=%h exp=0", out_data); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_in_ready got=%b exp=0", in_ready); end
    if (nop_count !== '0) begin n_fail++; $display("FAIL arst_nop got=%0d exp=0", nop_count); end
    sb_q.delete();
    @(negedge CLK);
    nRST      = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h99;
    out_ready = 1'b1;
    tick();
    n_checks += 2;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_rel_in_ready got=%b exp=1", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL arst_rel_valid got=%b exp=0", out_valid); end
    tick();
    in_valid = 1'b0;
    n_checks += 2;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL arst_lat_valid got=%b exp=1", out_valid); end
    if (out_data !== 32'h99) begin n_fail++; $display("FAIL arst_lat_data got=%h exp=99", out_data); end
    tick();
    n_checks++;
    if (occupancy !== 2'd0) begin n_fail++; $display("FAIL arst_drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_random();
    int start_deliv;
    start_deliv = n_deliv;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = ($urandom_range(99) < 70);
      out_ready = ($urandom_range(99) < 60);
      flush     = ($urandom_range(99) < 3);
      in_data   = $urandom;
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    n_checks += 2;
    if (sb_q.size() != 0) begin n_fail++; $display("FAIL rand_lost_beats got=%0d exp=0", sb_q.size()); end
    if (n_deliv - start_deliv < 1000) begin
      n_fail++;
      $display("FAIL rand_throughput got=%0d exp>=1000", n_deliv - start_deliv);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_counter();
    sb_on = 1'b1;
    test_stream();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_stage_reg.md
PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Parameters
REQ-001 SHALL have parameter DATA_W, default 32: width of the stage payload bus.
REQ-002 SHALL have parameter NOP_VALUE, default all-zeros of width DATA_W: bubble payload presented whenever the stage holds no valid beat.
REQ-003 SHALL have parameter CNT_W, default 16: width of the bubble statistics counter.

Interface
REQ-004 SHALL have port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port nRST, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port flush, input, 1 bit: synchronous squash of all stage contents (generalised NOP insertion).
REQ-007 SHALL have port in_valid, input, 1 bit: upstream offers a beat.
REQ-008 SHALL have port in_ready, output, 1 bit: stage can accept a beat; registered, not combinationally derived from out_ready.
REQ-009 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-010 SHALL have port out_valid, output, 1 bit: stage presents a valid beat.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts (low = stall).
REQ-012 SHALL have port out_data, output, DATA_W bits: payload, or NOP_VALUE when out_valid is 0.
REQ-013 SHALL have port occupancy, output, 2 bits: beats held (0..2).
REQ-014 SHALL have port nop_count, output, CNT_W bits: saturating count of bubble cycles.

Function
REQ-015 SHALL implement a 2-entry elastic buffer (main register driving outputs plus one skid register), giving full throughput with registered in_ready.
REQ-016 SHALL use states EMPTY (occupancy 0), ONE (1), TWO (2); occupancy SHALL equal the state encoding.
REQ-017 SHALL accept a beat on a cycle with in_valid && in_ready; SHALL deliver a beat on a cycle with out_valid && out_ready.
REQ-018 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in TWO.
REQ-019 SHALL drive out_valid = 1 in ONE and TWO and 0 in EMPTY.
REQ-020 EMPTY: accept -> ONE; beat appears on out_data the next cycle (latency 1).
REQ-021 ONE: accept without deliver -> TWO, beat stored in skid; deliver without accept -> EMPTY; accept and deliver -> ONE, new beat in main.
REQ-022 TWO: deliver -> ONE, skid beat moves to main; no deliver -> hold (stall); no accept possible.
REQ-023 SHALL deliver beats in acceptance order with no loss or duplication; out_data SHALL be stable while out_valid && !out_ready.
REQ-024 flush SHALL have highest priority: next state EMPTY, both registers set to NOP_VALUE, any beat offered that cycle discarded, any delivery that cycle still counted by downstream as completed.
REQ-025 out_data SHALL equal NOP_VALUE in every cycle where out_valid is 0.
REQ-026 nop_count SHALL increment by 1 on each rising edge where out_valid was 0, saturating at 2^CNT_W-1 (no wrap).
REQ-027 Simultaneous flush and in_valid from EMPTY SHALL leave the stage EMPTY.

Reset
REQ-028 On nRST low, immediately and independent of CLK: state EMPTY, in_ready 0 for the duration of reset, out_valid 0, out_data NOP_VALUE, occupancy 0, nop_count 0.
REQ-029 in_ready SHALL rise on the first rising edge after nRST deasserts; reset asserted mid-transfer SHALL discard all held beats.

Verification
REQ-030 Stream: DATA_W=32, out_ready=1, beats 0x1,0x2,0x3 back-to-back -> out_data 0x1,0x2,0x3 on consecutive cycles, starting 1 cycle after first accept, in_ready stays 1.
REQ-031 Stall: load 0xA,0xB with out_ready=0 -> occupancy 2, in_ready 0, out_data held 0xA; raise out_ready -> 0xA then 0xB, then occupancy 0.
REQ-032 Flush: occupancy 2 (0xA,0xB), assert flush with in_valid=1, in_data 0xC -> next cycle occupancy 0, out_valid 0, out_data 0x0; 0xA, 0xB, 0xC never appear.
REQ-033 Counter: CNT_W=4, idle 20 cycles after reset -> nop_count reaches 15 and holds at 15.
REQ-034 Async reset: assert nRST between clock edges while occupancy 1 -> outputs reach reset values before the next edge; after release, first beat has latency 1.
REQ-035 Random: random in_valid/out_ready/flush for 10k cycles against a FIFO scoreboard -> order preserved, no beat lost except by flush, occupancy never exceeds 2.
